// File: rtl/am_sched_pkg.sv
// rtl/am_sched_pkg.sv - shared types and widths for the AM source scheduler
package am_sched_pkg;

    localparam int SRC_ID_W = 1;
    localparam int SAMPLE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SETTLE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/am_sched_pick.sv
// rtl/am_sched_pick.sv - combinational next-grant selector (round-robin or fixed priority)
module am_sched_pick
    import am_sched_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic                prio_unused_tie,
    input  logic [SRC_ID_W-1:0] last_id,
    input  logic                s0_empty,
    input  logic                s1_empty,
    output logic                pick_valid,
    output logic [SRC_ID_W-1:0] pick_id
);

    logic [1:0]          w_avail;
    logic [SRC_ID_W-1:0] w_other;

    assign w_avail = {~s1_empty, ~s0_empty};
    assign w_other = ~last_id;

    always_comb begin
        pick_valid = |w_avail | (prio_unused_tie & 1'b0);
        pick_id    = '0;
        if (PRIO_MODE != 0) begin
            pick_id = w_avail[0] ? SRC_ID_W'(0) : SRC_ID_W'(1);
        end else begin
            // Prefer the source that did not hold the last grant.
            pick_id = w_avail[w_other] ? w_other : last_id;
        end
    end

endmodule

// File: rtl/am_source_scheduler.sv
// rtl/am_source_scheduler.sv - bursts one of two sample FIFOs into the AM modulator with settle gaps
module am_source_scheduler
    import am_sched_pkg::*;
#(
    parameter int BURST_LEN     = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int STARVE_CYCLES = 64,
    parameter int PRIO_MODE     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] s0_sample,
    input  logic                s0_empty,
    output logic                s0_read,
    input  logic [SAMPLE_W-1:0] s1_sample,
    input  logic                s1_empty,
    output logic                s1_read,
    output logic [SAMPLE_W-1:0] m_sample,
    output logic                m_empty,
    input  logic                m_read,
    output logic                grant_valid,
    output logic [SRC_ID_W-1:0] grant_id,
    output logic                burst_done,
    output logic                starve_evt
);

    localparam int BCW = $clog2(BURST_LEN + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int VCW = $clog2(STARVE_CYCLES + 1);

    sched_state_t        r_state;
    logic                r_grant_valid;
    logic [SRC_ID_W-1:0] r_grant_id;
    logic [SRC_ID_W-1:0] r_last_id;
    logic                r_burst_done;
    logic                r_starve_evt;
    logic [BCW-1:0]      r_burst_cnt;
    logic [SCW-1:0]      r_settle_cnt;
    logic [VCW-1:0]      r_starve_cnt;

    logic                w_in_grant;
    logic                w_gnt_empty;
    logic                w_oth_empty;
    logic                w_fwd;
    logic                w_starving;
    logic [SRC_ID_W-1:0] w_pick_last;
    logic                w_pick_valid;
    logic [SRC_ID_W-1:0] w_pick_id;

    assign w_in_grant  = (r_state == ST_GRANT);
    assign w_gnt_empty = r_grant_id[0] ? s1_empty : s0_empty;
    assign w_oth_empty = r_grant_id[0] ? s0_empty : s1_empty;
    assign w_fwd       = w_in_grant & m_read & ~w_gnt_empty;
    assign w_starving  = w_in_grant & w_gnt_empty & ~w_oth_empty;

    // The last SETTLE cycle picks as if last_id were already updated.
    assign w_pick_last = (r_state == ST_SETTLE) ? r_grant_id : r_last_id;

    assign s0_read     = w_fwd & ~r_grant_id[0];
    assign s1_read     = w_fwd &  r_grant_id[0];
    assign m_sample    = r_grant_id[0] ? s1_sample : s0_sample;
    assign m_empty     = ~w_in_grant | w_gnt_empty;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign burst_done  = r_burst_done;
    assign starve_evt  = r_starve_evt;

    am_sched_pick #(
        .PRIO_MODE(PRIO_MODE)
    ) u_pick (
        .prio_unused_tie(1'b0),
        .last_id        (w_pick_last),
        .s0_empty       (s0_empty),
        .s1_empty       (s1_empty),
        .pick_valid     (w_pick_valid),
        .pick_id        (w_pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_last_id     <= SRC_ID_W'(1);
            r_burst_done  <= 1'b0;
            r_starve_evt  <= 1'b0;
            r_burst_cnt   <= '0;
            r_settle_cnt  <= '0;
            r_starve_cnt  <= '0;
        end else begin
            r_burst_done <= 1'b0;
            r_starve_evt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_pick_valid) begin
                        r_state       <= ST_GRANT;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_pick_id;
                        r_burst_cnt   <= '0;
                        r_starve_cnt  <= '0;
                    end
                end
                ST_GRANT: begin
                    // Burst completion outranks starvation and disable.
                    if (w_fwd && r_burst_cnt == BCW'(BURST_LEN - 1)) begin
                        r_burst_cnt  <= r_burst_cnt + 1'b1;
                        r_burst_done <= 1'b1;
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end else if (w_starving && r_starve_cnt == VCW'(STARVE_CYCLES - 1)) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                        r_starve_evt <= 1'b1;
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end else begin
                        if (w_fwd) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                        r_starve_cnt <= w_starving ? r_starve_cnt + 1'b1 : '0;
                        if (!enable) begin
                            r_state      <= ST_SETTLE;
                            r_settle_cnt <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SCW'(SETTLE_CYCLES - 1)) begin
                        r_last_id <= r_grant_id;
                        if (enable && w_pick_valid) begin
                            r_state      <= ST_GRANT;
                            r_grant_id   <= w_pick_id;
                            r_burst_cnt  <= '0;
                            r_starve_cnt <= '0;
                        end else begin
                            r_state       <= ST_IDLE;
                            r_grant_valid <= 1'b0;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am_source_scheduler.sv
// tb/tb_am_source_scheduler.sv - directed self-checking bench for am_source_scheduler
module tb_am_source_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en   [2];
    logic       mrd  [2];
    int         lvl  [2][2];
    logic [7:0] smp  [2][2];
    logic       s0_rd[2], s1_rd[2], m_emp[2], gv[2], gid[2], bd[2], se[2];
    logic [7:0] msmp [2];

    int n_cmp = 0;
    int n_bad = 0;
    int pops  [2][2];
    int bd_cnt[2];
    int se_cnt[2];
    logic [31:0] pop_seq;
    bit   trk;
    int   gap_run;
    int   gaps[$];

    always #5 clk = ~clk;

    // Instance 0: round-robin, short bursts, short starvation limit.
    am_source_scheduler #(
        .BURST_LEN(4), .SETTLE_CYCLES(2), .STARVE_CYCLES(8), .PRIO_MODE(0)
    ) dut_rr (
        .clk(clk), .rst(rst), .enable(en[0]),
        .s0_sample(smp[0][0]), .s0_empty(lvl[0][0] == 0), .s0_read(s0_rd[0]),
        .s1_sample(smp[0][1]), .s1_empty(lvl[0][1] == 0), .s1_read(s1_rd[0]),
        .m_sample(msmp[0]), .m_empty(m_emp[0]), .m_read(mrd[0]),
        .grant_valid(gv[0]), .grant_id(gid[0]), .burst_done(bd[0]), .starve_evt(se[0])
    );

    // Instance 1: fixed priority, default-length bursts.
    am_source_scheduler #(
        .BURST_LEN(16), .SETTLE_CYCLES(2), .STARVE_CYCLES(64), .PRIO_MODE(1)
    ) dut_pr (
        .clk(clk), .rst(rst), .enable(en[1]),
        .s0_sample(smp[1][0]), .s0_empty(lvl[1][0] == 0), .s0_read(s0_rd[1]),
        .s1_sample(smp[1][1]), .s1_empty(lvl[1][1] == 0), .s1_read(s1_rd[1]),
        .m_sample(msmp[1]), .m_empty(m_emp[1]), .m_read(mrd[1]),
        .grant_valid(gv[1]), .grant_id(gid[1]), .burst_done(bd[1]), .starve_evt(se[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            bd_cnt[i] = 0;
            se_cnt[i] = 0;
            for (int s = 0; s < 2; s++) pops[i][s] = 0;
        end
    endtask

    // One clock: drive reads at negedge, sample strobes, pass the edge, update the FIFO models.
    task automatic step(input logic r0, input logic r1);
        logic p[2][2];
        mrd[0] = r0;
        mrd[1] = r1;
        #1;
        for (int i = 0; i < 2; i++) begin
            p[i][0] = s0_rd[i];
            p[i][1] = s1_rd[i];
            if (p[i][0]) check_eq("s0_data", msmp[i], smp[i][0]);
            if (p[i][1]) check_eq("s1_data", msmp[i], smp[i][1]);
        end
        if (trk) begin
            if (m_emp[0]) gap_run++;
            else if (gap_run > 0) begin
                gaps.push_back(gap_run);
                gap_run = 0;
            end
            if (p[0][0] || p[0][1]) pop_seq = {pop_seq[30:0], p[0][1]};
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (p[i][s]) begin
                    lvl[i][s]  = lvl[i][s] - 1;
                    smp[i][s]  = smp[i][s] + 8'd1;
                    pops[i][s] = pops[i][s] + 1;
                end
            end
            bd_cnt[i] += int'(bd[i]);
            se_cnt[i] += int'(se[i]);
        end
        mrd[0] = 1'b0;
        mrd[1] = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b1;
        trk = 1'b0;
        gap_run = 0;
        pop_seq = '0;
        en[0] = 1'b0; en[1] = 1'b0;
        mrd[0] = 1'b0; mrd[1] = 1'b0;
        smp[0][0] = 8'h10; smp[0][1] = 8'h80;
        smp[1][0] = 8'h20; smp[1][1] = 8'hA0;
        for (int i = 0; i < 2; i++) for (int s = 0; s < 2; s++) lvl[i][s] = 0;
        clear_stats();
        @(negedge clk);

        // Reset values with both sources full and enable high.
        lvl[0][0] = 100; lvl[0][1] = 100; en[0] = 1'b1;
        step(1'b1, 1'b0);
        check_eq("rst_gv", gv[0], 0);
        check_eq("rst_gid", gid[0], 0);
        check_eq("rst_m_empty", m_emp[0], 1);
        check_eq("rst_bd", bd[0], 0);
        check_eq("rst_se", se[0], 0);
        check_eq("rst_no_pop", pops[0][0] + pops[0][1], 0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        check_eq("first_gv", gv[0], 1);
        check_eq("first_gid", gid[0], 0);
        check_eq("first_m_empty", m_emp[0], 0);

        // Round-robin bursts of 4 with 2-cycle settle gaps.
        trk = 1'b1;
        for (int g = 0; g < 60 && (pops[0][0] + pops[0][1]) < 12; g++) step(1'b1, 1'b0);
        trk = 1'b0;
        check_eq("rr_pops", pops[0][0] + pops[0][1], 12);
        check_eq("rr_seq", pop_seq[11:0], 12'h0F0);
        check_eq("rr_gap_n", gaps.size(), 2);
        if (gaps.size() == 2) begin
            check_eq("rr_gap0", gaps[0], 2);
            check_eq("rr_gap1", gaps[1], 2);
        end
        check_eq("rr_bd_cnt", bd_cnt[0], 3);
        check_eq("rr_se_cnt", se_cnt[0], 0);
        check_eq("rr_settle_gv", gv[0], 1);
        check_eq("rr_settle_m_empty", m_emp[0], 1);

        // m_read while disabled in IDLE is ignored.
        lvl[1][0] = 50; lvl[1][1] = 50;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        check_eq("idle_no_pop", pops[1][0] + pops[1][1], 0);
        check_eq("idle_gv", gv[1], 0);
        check_eq("idle_m_empty", m_emp[1], 1);

        // Starvation: s0 drains after one read while s1 has data.
        rst = 1'b1;
        lvl[0][0] = 1; lvl[0][1] = 50;
        clear_stats();
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);
        check_eq("stv_gid", gid[0], 0);
        step(1'b1, 1'b0);
        check_eq("stv_pop", pops[0][0], 1);
        w = 0;
        while (!se[0] && w < 40) begin
            step(1'b0, 1'b0);
            w++;
        end
        check_eq("stv_latency", w, 8);
        check_eq("stv_settle_gv", gv[0], 1);
        check_eq("stv_settle_m_empty", m_emp[0], 1);
        step(1'b0, 1'b0);
        check_eq("stv_pulse_width", se[0], 0);
        step(1'b0, 1'b0);
        check_eq("stv_new_gid", gid[0], 1);
        check_eq("stv_new_m_empty", m_emp[0], 0);
        check_eq("stv_se_cnt", se_cnt[0], 1);

        // Fixed priority: s0 re-granted, reads during SETTLE ignored.
        lvl[1][0] = 100; lvl[1][1] = 100;
        clear_stats();
        en[1] = 1'b1;
        step(1'b0, 1'b1);
        for (int k = 0; k < 34; k++) step(1'b0, 1'b1);
        check_eq("pr_s0_pops", pops[1][0], 32);
        check_eq("pr_s1_pops", pops[1][1], 0);
        check_eq("pr_bd_cnt", bd_cnt[1], 2);
        check_eq("pr_settle_m_empty", m_emp[1], 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_eq("pr_settle_no_pop", pops[1][0], 32);
        check_eq("pr_regrant_gid", gid[1], 0);
        check_eq("pr_regrant_m_empty", m_emp[1], 0);

        // Enable dropped after 2 of 16 reads.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_eq("dis_pops", pops[1][0], 34);
        en[1] = 1'b0;
        step(1'b0, 1'b0);
        check_eq("dis_settle1_gv", gv[1], 1);
        check_eq("dis_settle1_m_empty", m_emp[1], 1);
        step(1'b0, 1'b1);
        check_eq("dis_settle2_gv", gv[1], 1);
        step(1'b0, 1'b1);
        check_eq("dis_idle_gv", gv[1], 0);
        check_eq("dis_idle_m_empty", m_emp[1], 1);
        check_eq("dis_idle_gid", gid[1], 0);
        step(1'b0, 1'b1);
        check_eq("dis_no_pop", pops[1][0] + pops[1][1], 34);
        check_eq("dis_bd_cnt", bd_cnt[1], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/am_source_scheduler.md
# am_source_scheduler

Time-multiplexes the single AM modulator between two 8-bit sample sources, each presented as a first-word-fall-through FIFO read port. Sits between the source FIFOs and the modulator's `sample`/`empty`/`read` port. Grants one source at a time in bursts of `BURST_LEN` samples. Inserts a settle gap before every grant change so the modulator never latches a sample from the wrong source. Also pre-empts a starved source when the other one has data.

## Interface
- `BURST_LEN`, 16: samples forwarded per grant before re-arbitration; ≥1.
- `SETTLE_CYCLES`, 2: clk cycles `m_empty` is forced high after a grant ends; must cover the modulator's read-to-latch delay (2 × clocks-per-PWM-step); ≥1.
- `STARVE_CYCLES`, 64: consecutive cycles the granted source must be empty while the other is non-empty before the scheduler pre-empts it; ≥1.
- `PRIO_MODE`, 0: 0 = round-robin; 1 = fixed priority to source 0.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  scheduler enable; low drains to IDLE.
- `s0_sample`  in  8  source 0 head-of-FIFO data.
- `s0_empty`  in  1  source 0 empty.
- `s0_read`  out  1  source 0 pop strobe.
- `s1_sample`  in  8  source 1 head-of-FIFO data.
- `s1_empty`  in  1  source 1 empty.
- `s1_read`  out  1  source 1 pop strobe.
- `m_sample`  out  8  data to modulator.
- `m_empty`  out  1  empty flag to modulator.
- `m_read`  in  1  modulator pop strobe, one-cycle pulse.
- `grant_valid`  out  1  a source is currently granted.
- `grant_id`  out  1  granted (or last granted) source.
- `burst_done`  out  1  one-cycle pulse when a burst completes.
- `starve_evt`  out  1  one-cycle pulse on a starvation pre-emption.

## Operation
- States: IDLE, GRANT, SETTLE.
- IDLE:
  - `m_empty`=1, `grant_valid`=0.
  - If `enable` and any source is non-empty, pick a source and go to GRANT.
  - Counters clear on entry to GRANT.
- Pick rule:
  - PRIO_MODE=1: source 0 if non-empty, else source 1.
  - PRIO_MODE=0: the source other than `last_id` if non-empty, else `last_id` if non-empty.
- GRANT:
  - `m_sample`/`m_empty` route combinationally from the granted source.
  - `sX_read` = `m_read` & granted & ~`sX_empty`.
  - Each forwarded read increments `burst_cnt`.
  - The read that brings `burst_cnt` to `BURST_LEN` pulses `burst_done` next cycle, then goes to SETTLE.
  - `starve_cnt` increments while the granted source is empty and the other is non-empty; any other cycle clears it.
  - At `STARVE_CYCLES` the block pulses `starve_evt` and goes to SETTLE.
  - `enable` low goes to SETTLE.
- SETTLE:
  - `m_empty`=1; no reads are forwarded.
  - `grant_id` holds its value and `grant_valid` stays 1.
  - After `SETTLE_CYCLES` cycles, set `last_id`=`grant_id`.
  - If `enable` and a source is pickable, go to GRANT with the new pick (may be the same source). Otherwise go to IDLE.
- `m_read` outside GRANT, or while the granted source is empty: ignored, not counted.
- `m_sample` outside GRANT: holds the last granted source's data.

## Timing
- Reset values:
  - state IDLE.
  - `grant_valid`=0, `grant_id`=0, `last_id`=1 (source 0 wins the first round-robin pick).
  - `burst_done`=0, `starve_evt`=0, `m_empty`=1.
  - `s0_read`=`s1_read`=0.
  - All counters 0.
- IDLE→GRANT: 1 cycle after the request is seen; `m_empty` reflects the source on the following cycle.
- Read path: combinational, zero latency from `m_read` to `sX_read`.
- Burst end:
  - Last read at cycle t.
  - `burst_done` and SETTLE at t+1.
  - New GRANT at t+1+`SETTLE_CYCLES`.
- Burst count and starvation are both reached in the same cycle: burst takes precedence; `starve_evt` is not pulsed.
- Reset mid-burst: immediate return to reset values; the pending modulator latch is the modulator's own concern.
- `burst_cnt` width: clog2(`BURST_LEN`+1). `starve_cnt` and `settle_cnt` widths follow their parameters the same way; none wrap.

## Structure
- Shared package `am_sched_pkg`: state encoding (IDLE=0, GRANT=1, SETTLE=2), `SRC_ID_W`=1, sample width 8.
- One sub-module, `am_sched_pick`: combinational next-grant selector. Inputs: `PRIO_MODE`, `last_id`, both empty flags. Outputs: `pick_valid`, `pick_id`.
- Top module holds the FSM, counters and mux.

## Test plan
- Reset with both sources non-empty, `enable`=1 → GRANT of source 0 one cycle later; `m_empty`=0 on the following cycle; `last_id` was 1.
- Both sources full, `BURST_LEN`=4, 12 modulator reads → pops alternate 4×s0, 4×s1, 4×s0; `m_empty`=1 for exactly 2 cycles between bursts; 3 `burst_done` pulses.
- s0 granted and empties after 1 read, s1 non-empty, `STARVE_CYCLES`=8 → `starve_evt` 8 cycles after s0 goes empty, then SETTLE, then GRANT s1.
- `PRIO_MODE`=1, both full → s0 re-granted after every SETTLE; s1 never popped.
- `m_read` pulsed during SETTLE and IDLE → no `sX_read`, `burst_cnt` unchanged.
- `enable` dropped mid-burst (2 of 16 read) → SETTLE for `SETTLE_CYCLES` cycles, then IDLE with `grant_valid`=0.
